// File: rtl/pql_pkg.sv
// Shared constants, FSM encoding and flattened-table indexing for the Q-learning policy reader.
// Entry (s, a) lives at flat index 4*s + a.
package pql_pkg;

  localparam int Q_W       = 24;
  localparam int Q_FRAC    = 16;
  localparam int N_STATES  = 6;
  localparam int N_ACTIONS = 4;
  localparam int N_ENTRIES = N_STATES * N_ACTIONS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_SCAN,
    ST_EMIT,
    ST_FIN
  } state_t;

  function automatic logic [4:0] q_idx(input logic [2:0] s, input logic [1:0] a);
    return {s, 2'b00} + {3'b000, a};
  endfunction

endpackage

// File: rtl/pql_qcmp.sv
// Combinational Q-entry comparator: signed greater-than against the running best,
// and the absolute change from the previous snapshot, computed one bit wider to avoid overflow.
module pql_qcmp #(
  parameter int W = 24
) (
  input  logic [W-1:0] cand,
  input  logic [W-1:0] best,
  input  logic [W-1:0] prev,
  output logic         gt,
  output logic [W:0]   abs_diff
);

  logic [W:0] diff;

  assign gt       = $signed(cand) > $signed(best);
  assign diff     = {cand[W-1], cand} - {prev[W-1], prev};
  assign abs_diff = diff[W] ? (~diff + 1'b1) : diff;

endmodule

// File: rtl/pql_policy_reader.sv
// Snapshots the 6x4 Q-table, scans one entry per cycle for each state's argmax, emits one record per
// state (first record 5 cycles after the START edge; OUT_READY low stalls the record and all later events).
module pql_policy_reader
  import pql_pkg::*;
#(
  parameter int             Q_W    = pql_pkg::Q_W,
  parameter logic [Q_W-1:0] THRESH = 24'h000100
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [N_ENTRIES*Q_W-1:0] Q_TABLE,
  input  logic                     START,
  output logic                     BUSY,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [2:0]               OUT_STATE,
  output logic [1:0]               OUT_ACTION,
  output logic [Q_W-1:0]           OUT_QMAX,
  output logic                     DONE,
  output logic                     CONVERGED
);

  state_t         state, st_nxt;
  logic [Q_W-1:0] cur  [N_ENTRIES];
  logic [Q_W-1:0] prev [N_ENTRIES];
  logic [2:0]     s_idx;
  logic [1:0]     a_idx;
  logic [Q_W-1:0] best;
  logic [1:0]     best_a;
  logic           conv_ok;
  logic           prev_vld;
  logic           converged_q;

  logic [4:0]     idx;
  logic [Q_W-1:0] cand;
  logic [Q_W-1:0] prv;
  logic           gt;
  logic [Q_W:0]   abs_diff;

  assign idx  = q_idx(s_idx, a_idx);
  assign cand = cur[idx];
  assign prv  = prev[idx];

  pql_qcmp #(.W(Q_W)) u_qcmp (
    .cand     (cand),
    .best     (best),
    .prev     (prv),
    .gt       (gt),
    .abs_diff (abs_diff)
  );

  always_comb begin
    st_nxt = state;
    unique case (state)
      ST_IDLE:    if (START) st_nxt = ST_CAPTURE;
      ST_CAPTURE: st_nxt = ST_SCAN;
      ST_SCAN:    if (a_idx == 2'd3) st_nxt = ST_EMIT;
      ST_EMIT:
        if (OUT_READY) st_nxt = (s_idx == 3'(N_STATES - 1)) ? ST_FIN : ST_SCAN;
      ST_FIN:     st_nxt = ST_IDLE;
      default:    st_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= ST_IDLE;
      s_idx       <= '0;
      a_idx       <= '0;
      best        <= '0;
      best_a      <= '0;
      conv_ok     <= 1'b0;
      prev_vld    <= 1'b0;
      converged_q <= 1'b0;
    end else begin
      state <= st_nxt;
      unique case (state)
        ST_CAPTURE: begin
          s_idx   <= '0;
          a_idx   <= '0;
          conv_ok <= 1'b1;
        end
        ST_SCAN: begin
          // Strict greater-than keeps the lower action index on ties.
          if (a_idx == 2'd0 || gt) begin
            best   <= cand;
            best_a <= a_idx;
          end
          if (abs_diff > {1'b0, THRESH}) conv_ok <= 1'b0;
          a_idx <= a_idx + 2'd1;
        end
        ST_EMIT: begin
          if (OUT_READY && s_idx != 3'(N_STATES - 1)) s_idx <= s_idx + 3'd1;
        end
        ST_FIN: begin
          converged_q <= conv_ok & prev_vld;
          prev_vld    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Table snapshots carry no reset; their contents only matter once prev_vld is set.
  always_ff @(posedge CLK) begin
    if (state == ST_CAPTURE) begin
      for (int i = 0; i < N_ENTRIES; i++) cur[i] <= Q_TABLE[i*Q_W +: Q_W];
    end
    if (state == ST_FIN) begin
      for (int i = 0; i < N_ENTRIES; i++) prev[i] <= cur[i];
    end
  end

  assign BUSY       = (state != ST_IDLE);
  assign OUT_VALID  = (state == ST_EMIT);
  assign OUT_STATE  = s_idx;
  assign OUT_ACTION = best_a;
  assign OUT_QMAX   = best;
  assign DONE       = (state == ST_FIN);
  assign CONVERGED  = converged_q;

endmodule
